mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_wait_timer.sv | 46 ++++
 rtl/mc_ctrl_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// ============================================================================
// Module   : mc_pkg
// Brief    : Shared state encodings, opcodes and datapath select codes for the
//            multicycle controller. HALT state exists only with MC_CTRL_HALT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_EXEC_I   = 4'd3,
      ST_MEM_ADDR = 4'd4,
      ST_MEM_RD   = 4'd5,
      ST_MEM_WR   = 4'd6,
      ST_WB_ALU   = 4'd7,
      ST_WB_MEM   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JUMP     = 4'd10,
      ST_FAULT    = 4'd11
`ifdef MC_CTRL_HALT_EN
      ,
      ST_HALT     = 4'd12
`endif
   } mc_state_e;

   localparam logic [3:0] c_OP_RTYPE = 4'b0000;
   localparam logic [3:0] c_OP_ADDI  = 4'b0001;
   localparam logic [3:0] c_OP_LW    = 4'b0010;
   localparam logic [3:0] c_OP_SW    = 4'b0011;
   localparam logic [3:0] c_OP_BEQ   = 4'b0100;
   localparam logic [3:0] c_OP_JAL   = 4'b0101;
   localparam logic [3:0] c_OP_HALT  = 4'b1111;

   localparam logic [1:0] c_ALU_ADD   = 2'b00;
   localparam logic [1:0] c_ALU_SUB   = 2'b01;
   localparam logic [1:0] c_ALU_FUNCT = 2'b10;
   localparam logic [1:0] c_ALU_PASSB = 2'b11;

   localparam logic [1:0] c_PC_INC    = 2'b00;
   localparam logic [1:0] c_PC_BRANCH = 2'b01;
   localparam logic [1:0] c_PC_JUMP   = 2'b10;

   localparam logic [1:0] c_SRCB_REG    = 2'b00;
   localparam logic [1:0] c_SRCB_ONE    = 2'b01;
   localparam logic [1:0] c_SRCB_IMM    = 2'b10;
   localparam logic [1:0] c_SRCB_BRANCH = 2'b11;

   localparam logic c_WB_ALU = 1'b0;
   localparam logic c_WB_MEM = 1'b1;

   // States that drive mem_req and therefore run the wait timer.
   function automatic logic f_is_req_state(input mc_state_e st);
      return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// Module   : mc_wait_timer
// Brief    : Counts memory wait cycles; expired flags the cycle in which the
//            count would reach MEM_TIMEOUT without a completion.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic tick,
   output logic expired
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // A completion in the final wait cycle suppresses tick, so it never expires.
   assign expired = tick && (cnt_q == CW'(MEM_TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
// ============================================================================
// Module   : mc_ctrl_fsm
// Brief    : Multicycle CPU control FSM with memory handshake timeout.
//            Define MC_CTRL_HALT_EN to make opcode 1111 enter a sticky HALT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       ir_en,
   output logic       ab_en,
   output logic       aluout_en,
   output logic       mdr_en,
   output logic       mem_req,
   output logic       mem_we,
   output logic       reg_we,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic [1:0] alu_srcb,
   output logic       wb_sel,
   output logic       fault,
   output logic [3:0] state
);

   mc_state_e state_q;
   mc_state_e state_d;
   logic      fault_q;
   logic      fault_d;

   logic      w_req;
   logic      w_tick;
   logic      w_clr;
   logic      w_expired;

   // Outputs are gated by rst so nothing is requested or enabled while it is high.
   assign w_req  = f_is_req_state(state_q) && !rst;
   assign w_tick = w_req && !mem_ready;
   assign w_clr  = !w_req || mem_ready;

   mc_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_clr),
      .tick    (w_tick),
      .expired (w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      fault_d   = fault_q | w_expired;
      pc_en     = 1'b0;
      ir_en     = 1'b0;
      ab_en     = 1'b0;
      aluout_en = 1'b0;
      mdr_en    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      alu_op    = c_ALU_ADD;
      pc_src    = c_PC_INC;
      alu_srcb  = c_SRCB_REG;
      wb_sel    = c_WB_ALU;

      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               mem_req  = 1'b1;
               alu_op   = c_ALU_ADD;
               pc_src   = c_PC_INC;
               alu_srcb = c_SRCB_ONE;
               if (mem_ready) begin
                  ir_en   = 1'b1;
                  pc_en   = 1'b1;
                  state_d = ST_DECODE;
               end else if (w_expired) begin
                  state_d = ST_FAULT;
               end
            end

            ST_DECODE: begin
               ab_en     = 1'b1;
               aluout_en = 1'b1;
               alu_op    = c_ALU_ADD;
               alu_srcb  = c_SRCB_BRANCH;
               case (opcode)
                  c_OP_RTYPE: state_d = ST_EXEC_R;
                  c_OP_ADDI:  state_d = ST_EXEC_I;
                  c_OP_LW,
                  c_OP_SW:    state_d = ST_MEM_ADDR;
                  c_OP_BEQ:   state_d = ST_BRANCH;
                  c_OP_JAL:   state_d = ST_JUMP;
`ifdef MC_CTRL_HALT_EN
                  c_OP_HALT:  state_d = ST_HALT;
`else
                  c_OP_HALT:  state_d = ST_FETCH;
`endif
                  default:    state_d = ST_FETCH;
               endcase
            end

            ST_EXEC_R: begin
               alu_op   = c_ALU_FUNCT;
               alu_srcb = c_SRCB_REG;
               state_d  = ST_WB_ALU;
            end

            ST_EXEC_I: begin
               alu_op   = c_ALU_ADD;
               alu_srcb = c_SRCB_IMM;
               state_d  = ST_WB_ALU;
            end

            ST_MEM_ADDR: begin
               alu_op   = c_ALU_ADD;
               alu_srcb = c_SRCB_IMM;
               state_d  = (opcode == c_OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end

            ST_MEM_RD: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  mdr_en  = 1'b1;
                  state_d = ST_WB_MEM;
               end else if (w_expired) begin
                  state_d = ST_FAULT;
               end
            end

            ST_MEM_WR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               if (mem_ready) begin
                  state_d = ST_FETCH;
               end else if (w_expired) begin
                  state_d = ST_FAULT;
               end
            end

            ST_WB_ALU: begin
               reg_we  = 1'b1;
               wb_sel  = c_WB_ALU;
               state_d = ST_FETCH;
            end

            ST_WB_MEM: begin
               reg_we  = 1'b1;
               wb_sel  = c_WB_MEM;
               state_d = ST_FETCH;
            end

            ST_BRANCH: begin
               alu_op   = c_ALU_SUB;
               alu_srcb = c_SRCB_REG;
               pc_src   = c_PC_BRANCH;
               pc_en    = zero;
               state_d  = ST_FETCH;
            end

            ST_JUMP: begin
               pc_en   = 1'b1;
               pc_src  = c_PC_JUMP;
               reg_we  = 1'b1;
               wb_sel  = c_WB_ALU;
               state_d = ST_FETCH;
            end

            // Only rst leaves FAULT; all datapath controls stay low.
            ST_FAULT: state_d = ST_FAULT;

`ifdef MC_CTRL_HALT_EN
            ST_HALT: state_d = ST_HALT;
`endif

            default: state_d = ST_FETCH;
         endcase
      end
   end

   assign fault = fault_q;
   assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Brief    : Directed self-checking bench for mc_ctrl_fsm with an expectation
//            queue; honours MC_CTRL_HALT_EN for the opcode 1111 case.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_ctrl_fsm;
   import mc_pkg::*;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = 4'b0000;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_en, ir_en, ab_en, aluout_en, mdr_en;
   logic       mem_req, mem_we, reg_we;
   logic [1:0] alu_op, pc_src, alu_srcb;
   logic       wb_sel, fault;
   logic [3:0] state;

   logic [3:0] cur_op = 4'b0000;

   // en: {pc,ir,ab,aluout,mdr,mem_req,mem_we,reg_we,fault}
   // s/m: {alu_op[1:0],pc_src[1:0],alu_srcb[1:0],wb_sel} value and check-mask
   typedef struct packed {
      logic [3:0] st;
      logic [8:0] en;
      logic [6:0] s;
      logic [6:0] m;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pc_en     (pc_en),
      .ir_en     (ir_en),
      .ab_en     (ab_en),
      .aluout_en (aluout_en),
      .mdr_en    (mdr_en),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .reg_we    (reg_we),
      .alu_op    (alu_op),
      .pc_src    (pc_src),
      .alu_srcb  (alu_srcb),
      .wb_sel    (wb_sel),
      .fault     (fault),
      .state     (state)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input mc_state_e st, input logic rdy,
                                  input logic z, input logic r);
      exp_t e;
      e    = '0;
      e.st = st;
      if (r) begin
         e.st = ST_FETCH;
         e.m  = '1;
         return e;
      end
      case (st)
         ST_FETCH: begin
            e.en[3] = 1'b1;
            if (rdy) begin
               e.en[8] = 1'b1;
               e.en[7] = 1'b1;
               e.m     = 7'b0011110;
               e.s     = 7'b0000010;
            end
         end
         ST_DECODE: begin
            e.en[6] = 1'b1;
            e.en[5] = 1'b1;
            e.m     = 7'b0000110;
            e.s     = 7'b0000110;
         end
         ST_MEM_RD: begin
            e.en[3] = 1'b1;
            e.en[4] = rdy;
         end
         ST_MEM_WR: begin
            e.en[3] = 1'b1;
            e.en[2] = 1'b1;
         end
         ST_WB_ALU: begin
            e.en[1] = 1'b1;
            e.m     = 7'b0000001;
            e.s     = 7'b0000000;
         end
         ST_WB_MEM: begin
            e.en[1] = 1'b1;
            e.m     = 7'b0000001;
            e.s     = 7'b0000001;
         end
         ST_BRANCH: begin
            e.m = 7'b1100000;
            e.s = 7'b0100000;
            if (z) begin
               e.en[8] = 1'b1;
               e.m     = 7'b1111000;
               e.s     = 7'b0101000;
            end
         end
         ST_JUMP: begin
            e.en[8] = 1'b1;
            e.en[1] = 1'b1;
            e.m     = 7'b0011001;
            e.s     = 7'b0010000;
         end
         ST_FAULT: begin
            e.en[0] = 1'b1;
            e.m     = '1;
         end
`ifdef MC_CTRL_HALT_EN
         ST_HALT: e.m = '1;
`endif
         default: ;
      endcase
      return e;
   endfunction

   task automatic step(input string tag, input mc_state_e st, input logic rdy,
                       input logic z, input logic r);
      exp_t       e;
      logic [8:0] en_o;
      logic [6:0] sel_o;
      @(negedge clk);
      rst       = r;
      mem_ready = rdy;
      zero      = z;
      opcode    = cur_op;
      sb.push_back(model(st, rdy, z, r));
      #1;
      e     = sb.pop_front();
      en_o  = {pc_en, ir_en, ab_en, aluout_en, mdr_en, mem_req, mem_we, reg_we, fault};
      sel_o = {alu_op, pc_src, alu_srcb, wb_sel};
      total++;
      assert (state === e.st) else begin
         bad++;
         $error("FAIL %s state got=%0d want=%0d", tag, state, e.st);
      end
      total++;
      assert (en_o === e.en) else begin
         bad++;
         $error("FAIL %s enables got=%b want=%b", tag, en_o, e.en);
      end
      total++;
      assert ((sel_o & e.m) === (e.s & e.m)) else begin
         bad++;
         $error("FAIL %s selects got=%b want=%b mask=%b", tag, sel_o, e.s, e.m);
      end
   endtask

   initial begin
      step("rst0", ST_FETCH, 1'b0, 1'b0, 1'b1);
      step("rst1", ST_FETCH, 1'b1, 1'b0, 1'b1);

      cur_op = c_OP_RTYPE;
      step("r_fetch", ST_FETCH,  1'b1, 1'b0, 1'b0);
      step("r_dec",   ST_DECODE, 1'b1, 1'b0, 1'b0);
      step("r_exec",  ST_EXEC_R, 1'b1, 1'b0, 1'b0);
      step("r_wb",    ST_WB_ALU, 1'b1, 1'b0, 1'b0);

      cur_op = c_OP_LW;
      for (int i = 0; i < 3; i++) step("lw_fwait", ST_FETCH, 1'b0, 1'b0, 1'b0);
      step("lw_fetch", ST_FETCH,    1'b1, 1'b0, 1'b0);
      step("lw_dec",   ST_DECODE,   1'b0, 1'b0, 1'b0);
      step("lw_addr",  ST_MEM_ADDR, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step("lw_rwait", ST_MEM_RD, 1'b0, 1'b0, 1'b0);
      step("lw_rd",    ST_MEM_RD,   1'b1, 1'b0, 1'b0);
      step("lw_wb",    ST_WB_MEM,   1'b0, 1'b0, 1'b0);

      cur_op = c_OP_BEQ;
      step("beq0_fetch", ST_FETCH,  1'b1, 1'b0, 1'b0);
      step("beq0_dec",   ST_DECODE, 1'b0, 1'b0, 1'b0);
      step("beq0_br",    ST_BRANCH, 1'b0, 1'b0, 1'b0);
      step("beq1_fetch", ST_FETCH,  1'b1, 1'b0, 1'b0);
      step("beq1_dec",   ST_DECODE, 1'b0, 1'b0, 1'b0);
      step("beq1_br",    ST_BRANCH, 1'b0, 1'b1, 1'b0);

      cur_op = c_OP_JAL;
      step("jal_fetch", ST_FETCH,  1'b1, 1'b0, 1'b0);
      step("jal_dec",   ST_DECODE, 1'b0, 1'b0, 1'b0);
      step("jal_jump",  ST_JUMP,   1'b1, 1'b0, 1'b0);

      cur_op = 4'b0111;
      step("nop_fetch", ST_FETCH,  1'b1, 1'b0, 1'b0);
      step("nop_dec",   ST_DECODE, 1'b0, 1'b0, 1'b0);

      // Completion on the last permitted wait cycle must not fault.
      cur_op = c_OP_SW;
      for (int i = 0; i < TO - 1; i++) step("edge_fwait", ST_FETCH, 1'b0, 1'b0, 1'b0);
      step("edge_fetch", ST_FETCH,    1'b1, 1'b0, 1'b0);
      step("sw_dec",     ST_DECODE,   1'b0, 1'b0, 1'b0);
      step("sw_addr",    ST_MEM_ADDR, 1'b0, 1'b0, 1'b0);
      step("sw_wr",      ST_MEM_WR,   1'b1, 1'b0, 1'b0);

      cur_op = c_OP_HALT;
      step("hlt_fetch", ST_FETCH,  1'b1, 1'b0, 1'b0);
      step("hlt_dec",   ST_DECODE, 1'b0, 1'b0, 1'b0);
`ifdef MC_CTRL_HALT_EN
      step("hlt_stay0", ST_HALT,   1'b1, 1'b0, 1'b0);
      step("hlt_stay1", ST_HALT,   1'b1, 1'b0, 1'b0);
`else
      step("hlt_nop",   ST_FETCH,  1'b0, 1'b0, 1'b0);
`endif
      step("hlt_rst",   ST_FETCH,  1'b0, 1'b0, 1'b1);

      cur_op = c_OP_SW;
      step("wr_fetch", ST_FETCH,    1'b1, 1'b0, 1'b0);
      step("wr_dec",   ST_DECODE,   1'b0, 1'b0, 1'b0);
      step("wr_addr",  ST_MEM_ADDR, 1'b0, 1'b0, 1'b0);
      step("wr_wait",  ST_MEM_WR,   1'b0, 1'b0, 1'b0);
      step("wr_rst0",  ST_FETCH,    1'b1, 1'b0, 1'b1);
      step("wr_rst1",  ST_FETCH,    1'b1, 1'b0, 1'b1);

      cur_op = c_OP_RTYPE;
      for (int i = 0; i < TO; i++) step("to_fwait", ST_FETCH, 1'b0, 1'b0, 1'b0);
      step("to_fault0", ST_FAULT,  1'b1, 1'b0, 1'b0);
      step("to_fault1", ST_FAULT,  1'b1, 1'b1, 1'b0);
      step("to_fault2", ST_FAULT,  1'b0, 1'b0, 1'b0);
      step("to_rst",    ST_FETCH,  1'b0, 1'b0, 1'b1);
      step("to_fetch",  ST_FETCH,  1'b1, 1'b0, 1'b0);
      step("to_dec",    ST_DECODE, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
